// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris keyboard input path: scan codes, action
// indices, horizontal auto-shift states and the key event payload.
package tetris_input_pkg;

  localparam logic [7:0] KEY_LEFT   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT  = 8'h74;
  localparam logic [7:0] KEY_DOWN   = 8'h72;
  localparam logic [7:0] KEY_ROTATE = 8'h75;
  localparam logic [7:0] KEY_DROP   = 8'h29;
  localparam logic [7:0] KEY_HOLD   = 8'h12;

  localparam int unsigned NUM_ACT = 6;

  // Bit positions in the held bitmap and the action pulse vector
  typedef enum logic [2:0] {
    ACT_LEFT   = 3'd0,
    ACT_RIGHT  = 3'd1,
    ACT_DOWN   = 3'd2,
    ACT_ROTATE = 3'd3,
    ACT_DROP   = 3'd4,
    ACT_HOLD   = 3'd5,
    ACT_NONE   = 3'd7
  } act_idx_t;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_DAS  = 2'd1,
    H_ARR  = 2'd2
  } h_state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       make;
  } key_event_t;

  function automatic act_idx_t decode_key(input logic [7:0] code);
    act_idx_t idx;
    case (code)
      KEY_LEFT:   idx = ACT_LEFT;
      KEY_RIGHT:  idx = ACT_RIGHT;
      KEY_DOWN:   idx = ACT_DOWN;
      KEY_ROTATE: idx = ACT_ROTATE;
      KEY_DROP:   idx = ACT_DROP;
      KEY_HOLD:   idx = ACT_HOLD;
      default:    idx = ACT_NONE;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/repeat_timer.sv
// Down-counter that flags expiry when an armed count reaches zero; load arms
// it with a new count, clear disarms it.
module repeat_timer
  import tetris_input_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  // Clear beats load; an idle armed counter stops at zero without wrapping
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (load_i) begin
      cnt_d    = load_val_i;
      active_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expire_c = active_q && (cnt_q == '0);

endmodule

// File: rtl/key_action_sequencer.sv
// Turns keyboard make/break events into one-cycle Tetris action pulses, with
// DAS/ARR auto-shift for left/right and repeat for soft drop.
module key_action_sequencer
  import tetris_input_pkg::*;
#(
  parameter int unsigned DAS_CYCLES = 16_000_000,
  parameter int unsigned ARR_CYCLES = 5_000_000,
  parameter int unsigned SDR_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] current_scan_code,
  input  logic       current_make_break,
  input  logic       key_event_valid,
  output logic       act_left,
  output logic       act_right,
  output logic       act_down,
  output logic       act_rotate,
  output logic       act_drop,
  output logic       act_hold,
  output logic [5:0] held
);

  localparam int unsigned MAX_HA  = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_HA > SDR_CYCLES) ? MAX_HA : SDR_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] DAS_LOAD = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LOAD = CNT_W'(ARR_CYCLES - 1);
  localparam logic [CNT_W-1:0] SDR_LOAD = CNT_W'(SDR_CYCLES - 1);

  logic               valid_q;
  logic [NUM_ACT-1:0] held_q, held_d;
  logic [NUM_ACT-1:0] act_q, act_d;
  h_state_t           h_state_q, h_state_d;
  logic               dir_q, dir_d;       // 0 = left, 1 = right

  logic               h_load, h_clear, sd_load, sd_clear;
  logic [CNT_W-1:0]   h_val;
  logic               h_exp_c, sd_exp_c;
  logic               ev_c, is_right_c;
  act_idx_t           key_c;
  key_event_t         kev;

  assign kev = '{code: current_scan_code, make: current_make_break};

  // Timer expiries are applied first so a same-cycle key event overrides them
  always_comb begin
    held_d    = held_q;
    act_d     = '0;
    h_state_d = h_state_q;
    dir_d     = dir_q;
    h_load    = 1'b0;
    h_clear   = 1'b0;
    h_val     = '0;
    sd_load   = 1'b0;
    sd_clear  = 1'b0;
    ev_c       = key_event_valid && !valid_q;
    key_c      = decode_key(kev.code);
    is_right_c = (key_c == ACT_RIGHT);

    if (!enable) begin
      held_d    = '0;
      h_state_d = H_IDLE;
      h_clear   = 1'b1;
      sd_clear  = 1'b1;
    end else begin
      if ((h_state_q != H_IDLE) && h_exp_c) begin
        act_d[dir_q] = 1'b1;
        h_load       = 1'b1;
        h_val        = ARR_LOAD;
        h_state_d    = H_ARR;
      end
      if (held_q[ACT_DOWN] && sd_exp_c) begin
        act_d[ACT_DOWN] = 1'b1;
        sd_load         = 1'b1;
      end

      if (ev_c && (key_c != ACT_NONE)) begin
        if (kev.make && !held_q[key_c]) begin
          held_d[key_c] = 1'b1;
          act_d[key_c]  = 1'b1;
          if ((key_c == ACT_LEFT) || is_right_c) begin
            act_d[ACT_LEFT]  = !is_right_c;
            act_d[ACT_RIGHT] = is_right_c;
            dir_d            = is_right_c;
            h_load           = 1'b1;
            h_val            = DAS_LOAD;
            h_state_d        = H_DAS;
          end
          if (key_c == ACT_DOWN) begin
            sd_load = 1'b1;
          end
        end else if (!kev.make && held_q[key_c]) begin
          held_d[key_c] = 1'b0;
          if (((key_c == ACT_LEFT) || is_right_c) && (is_right_c == dir_q)) begin
            act_d[ACT_LEFT]  = 1'b0;
            act_d[ACT_RIGHT] = 1'b0;
            if (held_q[!dir_q]) begin
              dir_d          = !dir_q;
              act_d[!dir_q]  = 1'b1;
              h_load         = 1'b1;
              h_val          = DAS_LOAD;
              h_state_d      = H_DAS;
            end else begin
              h_load    = 1'b0;
              h_clear   = 1'b1;
              h_state_d = H_IDLE;
            end
          end
          if (key_c == ACT_DOWN) begin
            act_d[ACT_DOWN] = 1'b0;
            sd_load         = 1'b0;
            sd_clear        = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      held_q    <= '0;
      act_q     <= '0;
      h_state_q <= H_IDLE;
      dir_q     <= 1'b0;
    end else begin
      valid_q   <= key_event_valid;
      held_q    <= held_d;
      act_q     <= act_d;
      h_state_q <= h_state_d;
      dir_q     <= dir_d;
    end
  end

  repeat_timer #(.CNT_W(CNT_W)) u_h_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (h_clear),
    .load_i     (h_load),
    .load_val_i (h_val),
    .expire_c   (h_exp_c)
  );

  repeat_timer #(.CNT_W(CNT_W)) u_sd_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (sd_clear),
    .load_i     (sd_load),
    .load_val_i (SDR_LOAD),
    .expire_c   (sd_exp_c)
  );

  assign act_left   = act_q[ACT_LEFT];
  assign act_right  = act_q[ACT_RIGHT];
  assign act_down   = act_q[ACT_DOWN];
  assign act_rotate = act_q[ACT_ROTATE];
  assign act_drop   = act_q[ACT_DROP];
  assign act_hold   = act_q[ACT_HOLD];
  assign held       = held_q;

endmodule

// File: tb/tb_key_action_sequencer.sv
// Scoreboard bench for key_action_sequencer: a fire-time reference model
// predicts each cycle's pulses and held bitmap; a monitor compares them.
module tb_key_action_sequencer;

  localparam int unsigned DAS = 20;
  localparam int unsigned ARR = 5;
  localparam int unsigned SDR = 4;

  logic       clk = 1'b0;
  logic       rst, enable, mb, valid;
  logic [7:0] code;
  logic       act_left, act_right, act_down, act_rotate, act_drop, act_hold;
  logic [5:0] held;

  key_action_sequencer #(
    .DAS_CYCLES(DAS), .ARR_CYCLES(ARR), .SDR_CYCLES(SDR)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .current_scan_code  (code),
    .current_make_break (mb),
    .key_event_valid    (valid),
    .act_left           (act_left),
    .act_right          (act_right),
    .act_down           (act_down),
    .act_rotate         (act_rotate),
    .act_drop           (act_drop),
    .act_hold           (act_hold),
    .held               (held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [5:0] act;
    logic [5:0] hld;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: absolute cycle numbers at which the next auto pulse fires
  logic [5:0] m_held;
  int         m_dir, h_fire, sd_fire;
  bit         m_vprev;

  function automatic int key_idx(input logic [7:0] c);
    case (c)
      8'h6B: return 0;
      8'h74: return 1;
      8'h72: return 2;
      8'h75: return 3;
      8'h29: return 4;
      8'h12: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    int         t;
    int         k;
    bit         ev;
    logic [5:0] a;
    t = cyc;
    a = '0;
    if (!rst) begin
      m_held = '0; h_fire = -1; sd_fire = -1; m_vprev = 0; m_dir = 0;
    end else begin
      ev = valid && !m_vprev && enable;
      m_vprev = valid;
      if (!enable) begin
        m_held = '0; h_fire = -1; sd_fire = -1;
      end else begin
        if (h_fire == t) begin a[m_dir] = 1'b1; h_fire = t + ARR; end
        if (sd_fire == t) begin a[2] = 1'b1; sd_fire = t + SDR; end
        k = key_idx(code);
        if (ev && k >= 0) begin
          if (mb && !m_held[k]) begin
            m_held[k] = 1'b1;
            a[k] = 1'b1;
            if (k < 2) begin a[1-k] = 1'b0; m_dir = k; h_fire = t + DAS; end
            if (k == 2) sd_fire = t + SDR;
          end else if (!mb && m_held[k]) begin
            m_held[k] = 1'b0;
            if (k < 2 && k == m_dir) begin
              a[0] = 1'b0; a[1] = 1'b0;
              if (m_held[1-k]) begin
                m_dir = 1 - k; a[m_dir] = 1'b1; h_fire = t + DAS;
              end else begin
                h_fire = -1;
              end
            end
            if (k == 2) begin a[2] = 1'b0; sd_fire = -1; end
          end
        end
      end
    end
    exp_q.push_back('{due: t + 1, act: a, hld: m_held});
  endtask

  // Monitor: compare every due prediction just after the edge that produced it
  initial begin
    exp_t       e;
    logic [5:0] got;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        got = {act_hold, act_drop, act_rotate, act_down, act_right, act_left};
        checks++;
        if (got !== e.act) begin
          failures++;
          $display("FAIL act cyc=%0d got=%b exp=%b", cyc, got, e.act);
        end
        checks++;
        if (held !== e.hld) begin
          failures++;
          $display("FAIL held cyc=%0d got=%b exp=%b", cyc, held, e.hld);
        end
        checks++;
        if (act_left && act_right) begin
          failures++;
          $display("FAIL lr_exclusive cyc=%0d got=11 exp=not both", cyc);
        end
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Strobe held for 4 cycles like the keyboard front end
  task automatic key(input logic [7:0] c, input logic m);
    code = c; mb = m; valid = 1'b1;
    idle(4);
    valid = 1'b0;
    tick();
  endtask

  logic [7:0] codes [7];

  initial begin
    int len, gap, sel;
    codes[0] = 8'h6B; codes[1] = 8'h74; codes[2] = 8'h72; codes[3] = 8'h75;
    codes[4] = 8'h29; codes[5] = 8'h12; codes[6] = 8'h1C;
    rst = 1'b0; enable = 1'b1; valid = 1'b0; code = 8'h00; mb = 1'b0;
    idle(3);
    rst = 1'b1;
    idle(2);

    // Left auto-shift, then release
    key(8'h6B, 1'b1); idle(40); key(8'h6B, 1'b0); idle(10);
    // Rotate with typematic repeats
    key(8'h75, 1'b1); key(8'h75, 1'b1); key(8'h75, 1'b1); key(8'h75, 1'b1); key(8'h75, 1'b0);
    // Left held, right takes over, right released hands back to left
    key(8'h6B, 1'b1); idle(8); key(8'h74, 1'b1); idle(25); key(8'h74, 1'b0); idle(10);
    key(8'h6B, 1'b0); idle(3);
    // Soft drop, released on an expiry cycle
    key(8'h72, 1'b1); idle(3); key(8'h72, 1'b0); idle(8);
    // Disable mid-ARR, re-enable without a new make
    key(8'h6B, 1'b1); idle(30); enable = 1'b0; idle(5); enable = 1'b1; idle(30);
    key(8'h6B, 1'b0); idle(3);
    // Reset mid-DAS, then drop and hold
    key(8'h6B, 1'b1); idle(5); rst = 1'b0; tick(); rst = 1'b1; idle(30);
    key(8'h29, 1'b1); key(8'h12, 1'b1); key(8'h29, 1'b0); key(8'h12, 1'b0); idle(3);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 6);
      code = codes[sel];
      mb = 1'($urandom_range(0, 2) != 0);
      len = $urandom_range(1, 5);
      gap = $urandom_range(1, 8);
      valid = 1'b1;
      idle(len);
      valid = 1'b0;
      idle(gap);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 79) == 0) begin rst = 1'b0; tick(); rst = 1'b1; end
      if ($urandom_range(0, 14) == 0) idle($urandom_range(10, 30));
    end
    enable = 1'b1;
    idle(5);
    @(posedge clk);
    #3;

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
